// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and redirect selection.
// Branch and jump redirects cost one bubble; flush_count tracks how many were taken.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [1:0]  jump,
    input  logic        j_jump,
    input  logic [31:0] rs_data,
    input  logic [31:0] fwd_data,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] link_addr,
    output logic [15:0] flush_count
);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [15:0] fcnt_q, fcnt_d;

    logic [31:0] pc_plus4;
    logic        jump_req;
    logic        redirect;
    logic [31:0] target;

    assign pc_plus4 = pc_q + 32'd4;
    assign jump_req = valid_q && ((jump != 2'b00) || j_jump);
    assign redirect = branch_taken || jump_req;

    always_comb begin
        target = {pc4_q[31:28], instr_q[25:0], 2'b00};
        if (branch_taken) begin
            target = branch_target;
        end else if (jump == 2'b10) begin
            target = fwd_data;
        end else if (jump == 2'b01) begin
            target = rs_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            StBoot: begin
                // Boot fetch always proceeds; decode has nothing live to redirect yet.
                state_d = StRun;
                pc_d    = {pc_plus4[31:2], 2'b00};
                instr_d = imem_rdata;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
            StRun: begin
                if (!stall) begin
                    if (redirect) begin
                        pc_d    = {target[31:2], 2'b00};
                        instr_d = 32'h0;
                        valid_d = 1'b0;
                        if (fcnt_q != 16'hFFFF) begin
                            fcnt_d = fcnt_q + 16'd1;
                        end
                    end else begin
                        pc_d    = {pc_plus4[31:2], 2'b00};
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            pc_q    <= ResetPcAligned;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            fcnt_q  <= 16'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign link_addr   = pc4_q;
    assign flush_count = fcnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference model pushes expected IF state per cycle into a
// scoreboard queue, popped and compared one cycle later; plus fixed-value checks of key vectors.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [1:0]  jump;
    logic        j_jump;
    logic [31:0] rs_data;
    logic [31:0] fwd_data;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] link_addr;
    logic [15:0] flush_count;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .j_jump       (j_jump),
        .rs_data      (rs_data),
        .fwd_data     (fwd_data),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .link_addr    (link_addr),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: address-tagged words, with a j instruction planted at 0x1000_000C.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == 32'h1000_000C) ? 32'h0800_0040 : ~a;
    endfunction

    assign imem_rdata = word_at(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];

    int   n_checks;
    int   n_fails;

    // Reference model state
    logic        m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [15:0] m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_fc    = 16'h0;
        sb.delete();
    endtask

    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        if (m_boot) begin
            m_boot  = 1'b0;
            m_instr = word_at(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
        end else if (!stall) begin
            redir = branch_taken || (m_valid && (jump != 2'b00 || j_jump));
            if (branch_taken)       tgt = branch_target;
            else if (jump == 2'b10) tgt = fwd_data;
            else if (jump == 2'b01) tgt = rs_data;
            else                    tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
            if (redir) begin
                m_pc    = tgt & 32'hFFFF_FFFC;
                m_instr = 32'h0;
                m_valid = 1'b0;
                if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
            end else begin
                m_instr = word_at(m_pc);
                m_pc4   = m_pc + 32'd4;
                m_pc    = m_pc + 32'd4;
                m_valid = 1'b1;
            end
        end
    endtask

    // Drive decode-side inputs, predict, clock, then compare one sample after the edge.
    task automatic step(input logic bt, input logic [31:0] tgt, input logic [1:0] jmp,
                        input logic jj, input logic st);
        exp_t e;
        branch_taken  = bt;
        branch_target = tgt;
        jump          = jmp;
        j_jump        = jj;
        stall         = st;
        model_step();
        e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, fc: m_fc};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("pc", imem_addr, e.pc);
            chk("instr", if_id_instr, e.instr);
            chk("pc4", if_id_pc4, e.pc4);
            chk("valid", {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("link", link_addr, e.pc4);
            chk("fcount", {16'd0, flush_count}, {16'd0, e.fc});
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, if_id_instr, 32'h0);
        chk({tag, "_pc4"}, if_id_pc4, 32'h0);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_link"}, link_addr, 32'h0);
        chk({tag, "_fc"}, {16'd0, flush_count}, 32'd0);
    endtask

    logic [15:0] fc_before;

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 2'b00;
        j_jump        = 1'b0;
        rs_data       = 32'h0;
        fwd_data      = 32'h0;
        model_reset();

        #2;
        check_reset_outputs("rst0");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        rst_n = 1'b1;

        // Boot and sequential fetch
        idle();
        chk("boot_pc4", if_id_pc4, 32'd4);
        chk("boot_valid", {31'd0, if_id_valid}, 32'd1);
        idle();
        chk("seq_pc4", if_id_pc4, 32'd8);
        idle();

        // jr forwarded vs register value, with low bits stripped
        fwd_data = 32'h0000_2003;
        rs_data  = 32'h0000_5000;
        step(1'b0, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("jr_fwd_pc", imem_addr, 32'h0000_2000);
        idle();
        step(1'b0, 32'h0, 2'b01, 1'b0, 1'b0);
        chk("jr_rs_pc", imem_addr, 32'h0000_5000);
        // Jump request against a bubble is not a redirect
        step(1'b0, 32'h0, 2'b01, 1'b0, 1'b0);
        idle();

        // Stall beats a simultaneous branch, then the branch lands
        step(1'b1, 32'h80, 2'b00, 1'b0, 1'b1);
        step(1'b1, 32'h80, 2'b00, 1'b0, 1'b1);
        step(1'b1, 32'h80, 2'b00, 1'b0, 1'b0);
        chk("br_pc", imem_addr, 32'h80);
        idle();

        // Branch outranks a concurrent jal
        step(1'b1, 32'h0000_0400, 2'b11, 1'b0, 1'b0);
        chk("prio_pc", imem_addr, 32'h0000_0400);
        idle();

        // j instruction: pc4 0x1000_0010, instr 0x0800_0040
        step(1'b1, 32'h1000_000C, 2'b00, 1'b0, 1'b0);
        idle();
        chk("j_instr", if_id_instr, 32'h0800_0040);
        chk("j_pc4", if_id_pc4, 32'h1000_0010);
        fc_before = flush_count;
        step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("j_pc", imem_addr, 32'h1000_0100);
        chk("j_bubble", {31'd0, if_id_valid}, 32'd0);
        chk("j_fc", {16'd0, flush_count}, {16'd0, fc_before + 16'd1});
        idle();

        // PC wraps modulo 2^32
        step(1'b1, 32'hFFFF_FFFC, 2'b00, 1'b0, 1'b0);
        idle();
        chk("wrap_pc", imem_addr, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h0);

        // Drive flush_count into saturation
        for (int i = 0; i < 65540; i++) begin
            step(1'b1, 32'h100, 2'b00, 1'b0, 1'b0);
        end
        chk("sat_fc", {16'd0, flush_count}, 32'h0000_FFFF);
        step(1'b1, 32'h200, 2'b00, 1'b0, 1'b0);
        chk("sat_hold", {16'd0, flush_count}, 32'h0000_FFFF);

        // Asynchronous reset mid-cycle during a redirect request
        #2;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0300;
        rst_n         = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(posedge clk);
        #1;
        chk("async_hold_pc", imem_addr, 32'h0);
        rst_n = 1'b1;
        idle();
        chk("post_rst_instr", if_id_instr, word_at(32'h0));
        chk("post_rst_pc4", if_id_pc4, 32'd4);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
